// File: rtl/read_return_path_pkg.sv
// Shared system-bus definitions: data width and slave-select encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package read_return_path_pkg;

  localparam int BUS_DATA_W = 32;

  // Slave-select encoding, common to the address decoder and both data muxes
  typedef logic slv_sel_t;
  localparam slv_sel_t SLV0 = 1'b0;
  localparam slv_sel_t SLV1 = 1'b1;

  function automatic logic is_slv1(input slv_sel_t sel);
    return sel == SLV1;
  endfunction

endpackage

// File: rtl/read_return_path_sel_order_fifo.sv
// Order FIFO of slave selects for accepted reads, oldest at the head.
// Latency: push visible at head/count one cycle later; pop takes effect next cycle.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
module sel_order_fifo
  import read_return_path_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  slv_sel_t         i_din,
  output slv_sel_t         o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  slv_sel_t    r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = CNT_W'(r_wr_ptr - r_rd_ptr);

  // Advance write/read pointers; they wrap naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/read_return_path.sv
// Returns read data from two slaves to the master in address-issue order.
// Latency: 1 cycle from slave handshake to m_rvalid; 1 beat/cycle sustained.
// Backpressure: slave rready only when the head slave matches and the output stage is free.
module read_return_path
  import read_return_path_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_valid,
  input  logic              ar_sel,
  output logic              ar_ready,
  input  logic              s0_rvalid,
  input  logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rready,
  input  logic              s1_rvalid,
  input  logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rready,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  input  logic              m_rready,
  output logic [CNT_W-1:0]  outstanding
);

  logic              r_rst_meta;
  logic              r_rst_sync;
  logic              w_rst_n;
  slv_sel_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_push;
  logic              w_out_free;
  logic              w_s0_hs;
  logic              w_s1_hs;
  logic              w_load;
  logic [DATA_W-1:0] w_rdata;
  logic              r_m_rvalid;
  logic [DATA_W-1:0] r_m_rdata;

  // Reset asserts immediately but releases only after two clean clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Full depends on stored entries only, so a same-cycle pop never frees a slot
  assign ar_ready = !w_full;
  assign w_push   = ar_valid && ar_ready;

  sel_order_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_sel_order_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_din   (ar_sel),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  // Only the head slave is offered rready; the other slave's beat waits untouched
  assign w_out_free = !r_m_rvalid || m_rready;
  assign s0_rready  = !w_empty && (w_head == SLV0) && w_out_free;
  assign s1_rready  = !w_empty && (w_head == SLV1) && w_out_free;
  assign w_s0_hs    = s0_rvalid && s0_rready;
  assign w_s1_hs    = s1_rvalid && s1_rready;
  assign w_load     = w_s0_hs || w_s1_hs;
  assign w_rdata    = is_slv1(w_head) ? s1_rdata : s0_rdata;

  // Output stage: load on slave handshake, otherwise drain on master handshake
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_m_rvalid <= 1'b0;
      r_m_rdata  <= '0;
    end else if (w_load) begin
      r_m_rvalid <= 1'b1;
      r_m_rdata  <= w_rdata;
    end else if (m_rready) begin
      r_m_rvalid <= 1'b0;
    end
  end

  assign m_rvalid = r_m_rvalid;
  assign m_rdata  = r_m_rdata;

  // Reads in flight = entries awaiting a slave + the beat waiting for the master
  assign outstanding = w_fifo_count + {{(CNT_W-1){1'b0}}, r_m_rvalid};

endmodule

// File: tb/tb_read_return_path.sv
module tb_read_return_path;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ar_valid, ar_sel, ar_ready;
  logic              s0_rvalid, s0_rready, s1_rvalid, s1_rready;
  logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
  logic              m_rvalid, m_rready;
  logic [CNT_W-1:0]  outstanding;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  read_return_path #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_sel(ar_sel), .ar_ready(ar_ready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rready(s0_rready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rready(s1_rready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .outstanding(outstanding)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ar_valid = 0; ar_sel = 0; m_rready = 0;
    s0_rvalid = 0; s0_rdata = '0; s1_rvalid = 0; s1_rdata = '0;
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 0;
    #1;
    n_checks++; if (m_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_m_rvalid got %b want 0", m_rvalid); end
    n_checks++; if (m_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_m_rdata got %h want 0", m_rdata); end
    n_checks++; if (ar_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ar_ready got %b want 1", ar_ready); end
    n_checks++; if (s0_rready !== 1'b0) begin n_errors++; $display("FAIL rst_s0_rready got %b want 0", s0_rready); end
    n_checks++; if (s1_rready !== 1'b0) begin n_errors++; $display("FAIL rst_s1_rready got %b want 0", s1_rready); end
    n_checks++; if (outstanding !== 0) begin n_errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) cyc();
  endtask

  task automatic test_in_order();
    m_rready = 1;
    ar_valid = 1; ar_sel = 1; cyc();
    ar_sel = 0; cyc();
    ar_valid = 0; s0_rvalid = 1; s0_rdata = 32'hAAAA0000; #1;
    n_checks++; if (s0_rready !== 1'b0) begin n_errors++; $display("FAIL order_s0_blocked got %b want 0", s0_rready); end
    n_checks++; if (outstanding !== 2) begin n_errors++; $display("FAIL order_out2 got %0d want 2", outstanding); end
    cyc();
    s1_rvalid = 1; s1_rdata = 32'h11111111; #1;
    n_checks++; if (s0_rready !== 1'b0 || s1_rready !== 1'b1) begin n_errors++; $display("FAIL order_s1_head got s0r=%b s1r=%b want 0 1", s0_rready, s1_rready); end
    cyc();
    s1_rvalid = 0; #1;
    n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h11111111) begin n_errors++; $display("FAIL order_first got v=%b d=%h want 1 11111111", m_rvalid, m_rdata); end
    n_checks++; if (s0_rready !== 1'b1) begin n_errors++; $display("FAIL order_s0_ready got %b want 1", s0_rready); end
    cyc();
    s0_rvalid = 0; #1;
    n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hAAAA0000) begin n_errors++; $display("FAIL order_second got v=%b d=%h want 1 aaaa0000", m_rvalid, m_rdata); end
    n_checks++; if (outstanding !== 1) begin n_errors++; $display("FAIL order_out1 got %0d want 1", outstanding); end
    cyc();
    n_checks++; if (m_rvalid !== 1'b0 || outstanding !== 0) begin n_errors++; $display("FAIL order_done got v=%b out=%0d want 0 0", m_rvalid, outstanding); end
    idle();
  endtask

  task automatic test_full();
    m_rready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      ar_valid = 1; ar_sel = 0; #1;
      n_checks++; if (ar_ready !== 1'b1) begin n_errors++; $display("FAIL full_accept%0d got %b want 1", i, ar_ready); end
      cyc();
    end
    #1;
    n_checks++; if (ar_ready !== 1'b0 || outstanding !== DEPTH) begin n_errors++; $display("FAIL full_flag got rdy=%b out=%0d want 0 %0d", ar_ready, outstanding, DEPTH); end
    s0_rvalid = 1; s0_rdata = 32'h100; #1;
    n_checks++; if (s0_rready !== 1'b1 || ar_ready !== 1'b0) begin n_errors++; $display("FAIL full_pop_same got s0r=%b rdy=%b want 1 0", s0_rready, ar_ready); end
    cyc();
    s0_rvalid = 0; #1;
    n_checks++; if (ar_ready !== 1'b1 || m_rvalid !== 1'b1) begin n_errors++; $display("FAIL full_freed got rdy=%b v=%b want 1 1", ar_ready, m_rvalid); end
    cyc();
    ar_valid = 0; #1;
    n_checks++; if (ar_ready !== 1'b0 || outstanding !== DEPTH) begin n_errors++; $display("FAIL full_fifth got rdy=%b out=%0d want 0 %0d", ar_ready, outstanding, DEPTH); end
    s0_rvalid = 1;
    repeat (DEPTH) cyc();
    s0_rvalid = 0;
    cyc(); cyc();
    n_checks++; if (outstanding !== 0) begin n_errors++; $display("FAIL full_drain got %0d want 0", outstanding); end
    idle();
  endtask

  task automatic test_backpressure();
    m_rready = 0;
    ar_valid = 1; ar_sel = 0; cyc(); cyc();
    ar_valid = 0; s0_rvalid = 1; s0_rdata = 32'h1; #1;
    n_checks++; if (s0_rready !== 1'b1) begin n_errors++; $display("FAIL bp_first_ready got %b want 1", s0_rready); end
    cyc();
    s0_rdata = 32'h2;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h1) begin n_errors++; $display("FAIL bp_hold%0d got v=%b d=%h want 1 1", i, m_rvalid, m_rdata); end
      n_checks++; if (s0_rready !== 1'b0) begin n_errors++; $display("FAIL bp_stall%0d got %b want 0", i, s0_rready); end
      cyc();
    end
    m_rready = 1; #1;
    n_checks++; if (s0_rready !== 1'b1) begin n_errors++; $display("FAIL bp_release got %b want 1", s0_rready); end
    cyc();
    s0_rvalid = 0; #1;
    n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h2) begin n_errors++; $display("FAIL bp_second got v=%b d=%h want 1 2", m_rvalid, m_rdata); end
    cyc();
    n_checks++; if (m_rvalid !== 1'b0 || outstanding !== 0) begin n_errors++; $display("FAIL bp_done got v=%b out=%0d want 0 0", m_rvalid, outstanding); end
    idle();
  endtask

  task automatic test_spurious();
    m_rready = 1; s1_rvalid = 1; s1_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (s1_rready !== 1'b0 || m_rvalid !== 1'b0 || outstanding !== 0) begin n_errors++; $display("FAIL spurious%0d got s1r=%b v=%b out=%0d want 0 0 0", i, s1_rready, m_rvalid, outstanding); end
      cyc();
    end
    idle();
  endtask

  task automatic test_simultaneous();
    m_rready = 1;
    ar_valid = 1; ar_sel = 0; cyc();
    ar_sel = 1; s0_rvalid = 1; s0_rdata = 32'hA1; #1;
    n_checks++; if (s0_rready !== 1'b1) begin n_errors++; $display("FAIL sim_s0_ready got %b want 1", s0_rready); end
    cyc();
    ar_sel = 0; s0_rvalid = 0; s1_rvalid = 1; s1_rdata = 32'hB2; #1;
    n_checks++; if (outstanding !== 2 || s1_rready !== 1'b1 || ar_ready !== 1'b1) begin n_errors++; $display("FAIL sim_pre got out=%0d s1r=%b rdy=%b want 2 1 1", outstanding, s1_rready, ar_ready); end
    n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hA1) begin n_errors++; $display("FAIL sim_a1 got v=%b d=%h want 1 a1", m_rvalid, m_rdata); end
    cyc();
    ar_valid = 0; s1_rvalid = 0; s0_rvalid = 1; s0_rdata = 32'hC3; #1;
    n_checks++; if (outstanding !== 2) begin n_errors++; $display("FAIL sim_out_same got %0d want 2", outstanding); end
    n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hB2) begin n_errors++; $display("FAIL sim_b2 got v=%b d=%h want 1 b2", m_rvalid, m_rdata); end
    cyc();
    s0_rvalid = 0; #1;
    n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hC3 || outstanding !== 1) begin n_errors++; $display("FAIL sim_c3 got v=%b d=%h out=%0d want 1 c3 1", m_rvalid, m_rdata, outstanding); end
    cyc();
    n_checks++; if (m_rvalid !== 1'b0 || outstanding !== 0) begin n_errors++; $display("FAIL sim_done got v=%b out=%0d want 0 0", m_rvalid, outstanding); end
    idle();
  endtask

  task automatic test_reset_mid();
    m_rready = 0;
    ar_valid = 1; ar_sel = 0; cyc();
    ar_valid = 0; s0_rvalid = 1; s0_rdata = 32'h5555AAAA; cyc();
    s0_rvalid = 0; #1;
    n_checks++; if (m_rvalid !== 1'b1 || outstanding !== 1) begin n_errors++; $display("FAIL rmid_pre got v=%b out=%0d want 1 1", m_rvalid, outstanding); end
    rst_n = 0; #1;
    n_checks++; if (m_rvalid !== 1'b0 || outstanding !== 0 || ar_ready !== 1'b1 || m_rdata !== 32'h0) begin n_errors++; $display("FAIL rmid_async got v=%b out=%0d rdy=%b d=%h want 0 0 1 0", m_rvalid, outstanding, ar_ready, m_rdata); end
    cyc(); cyc();
    rst_n = 1; m_rready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (m_rvalid !== 1'b0 || outstanding !== 0) begin n_errors++; $display("FAIL rmid_quiet%0d got v=%b out=%0d want 0 0", i, m_rvalid, outstanding); end
    end
    idle();
  endtask

  task automatic test_random(input int ncyc);
    bit ord_q[$];
    logic [DATA_W-1:0] sq0[$];
    logic [DATA_W-1:0] sq1[$];
    bit pres0 = 0, pres1 = 0, exp_v = 0, drain;
    logic [DATA_W-1:0] exp_d = '0;
    int n_out = 0;
    bit hd, free, e0, e1, acc, mhs, hs0, hs1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      drain = (c >= ncyc - 60);
      ar_valid = drain ? 1'b0 : (($urandom % 3) != 0);
      ar_sel = $urandom % 2;
      m_rready = drain ? 1'b1 : (($urandom % 4) != 0);
      if (sq0.size() > 0) begin
        if (!pres0) pres0 = drain ? 1'b1 : 1'($urandom % 2);
        s0_rvalid = pres0; s0_rdata = sq0[0];
      end else begin
        s0_rvalid = (($urandom % 8) == 0); s0_rdata = $urandom;
      end
      if (sq1.size() > 0) begin
        if (!pres1) pres1 = drain ? 1'b1 : 1'($urandom % 2);
        s1_rvalid = pres1; s1_rdata = sq1[0];
      end else begin
        s1_rvalid = (($urandom % 8) == 0); s1_rdata = $urandom;
      end
      @(negedge clk);
      hd   = (ord_q.size() > 0) ? ord_q[0] : 1'b0;
      free = !exp_v || m_rready;
      e0   = (ord_q.size() > 0) && !hd && free;
      e1   = (ord_q.size() > 0) && hd && free;
      n_checks++; if (ar_ready !== (ord_q.size() < DEPTH)) begin n_errors++; $display("FAIL rnd_ar_ready c=%0d got %b want %b", c, ar_ready, ord_q.size() < DEPTH); end
      n_checks++; if (s0_rready !== e0) begin n_errors++; $display("FAIL rnd_s0_rready c=%0d got %b want %b", c, s0_rready, e0); end
      n_checks++; if (s1_rready !== e1) begin n_errors++; $display("FAIL rnd_s1_rready c=%0d got %b want %b", c, s1_rready, e1); end
      n_checks++; if (outstanding !== CNT_W'(n_out)) begin n_errors++; $display("FAIL rnd_outstanding c=%0d got %0d want %0d", c, outstanding, n_out); end
      n_checks++; if (m_rvalid !== exp_v) begin n_errors++; $display("FAIL rnd_m_rvalid c=%0d got %b want %b", c, m_rvalid, exp_v); end
      if (exp_v) begin
        n_checks++; if (m_rdata !== exp_d) begin n_errors++; $display("FAIL rnd_m_rdata c=%0d got %h want %h", c, m_rdata, exp_d); end
      end
      acc = ar_valid && (ord_q.size() < DEPTH);
      mhs = exp_v && m_rready;
      hs0 = s0_rvalid && e0;
      hs1 = s1_rvalid && e1;
      if (hs0) begin
        void'(ord_q.pop_front()); exp_d = sq0.pop_front(); pres0 = 0; exp_v = 1;
      end else if (hs1) begin
        void'(ord_q.pop_front()); exp_d = sq1.pop_front(); pres1 = 0; exp_v = 1;
      end else if (mhs) begin
        exp_v = 0;
      end
      if (mhs) n_out--;
      if (acc) begin
        ord_q.push_back(ar_sel);
        n_out++;
        if (ar_sel) sq1.push_back($urandom); else sq0.push_back($urandom);
      end
    end
    @(posedge clk); #1;
    n_checks++; if (outstanding !== 0 || n_out != 0) begin n_errors++; $display("FAIL rnd_final got out=%0d model=%0d want 0 0", outstanding, n_out); end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_backpressure();
    test_spurious();
    test_simultaneous();
    test_reset_mid();
    test_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
